// File: rtl/sap1_ctrl_pkg.sv
// Shared SAP-1 control definitions: sequencer states, counter width and the
// control-word bit positions the decoder and sequencer both agree on.
package sap1_ctrl_pkg;
  localparam int CW_WIDTH = 16;
  localparam int CNT_W    = 16;

  // Bit positions within the decoded control word
  localparam int C_HLT = 15;
  localparam int C_ADV = 14;
  localparam int C_EL  = 13;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } seq_state_t;
endpackage

// File: rtl/step_sequencer_if.sv
// Decoder/datapath-facing bundle of the step sequencer.
interface step_sequencer_if
  import sap1_ctrl_pkg::*;
#(
  parameter int CONTROL_WORD_WIDTH = CW_WIDTH,
  parameter int STEP_WIDTH         = 3
);
  logic [CONTROL_WORD_WIDTH-1:0] i_control_word;
  logic                          i_alu_zero;
  logic                          i_alu_carry;
  logic                          i_alu_odd;
  logic                          i_run;
  logic                          i_step_req;
  logic [STEP_WIDTH-1:0]         o_step;
  logic                          o_zero;
  logic                          o_carry;
  logic                          o_odd;
  logic                          o_exec;
  logic                          o_halted;
  logic                          o_fault;
  logic [CNT_W-1:0]              o_instr_count;

  modport master (
    output i_control_word, i_alu_zero, i_alu_carry, i_alu_odd, i_run, i_step_req,
    input  o_step, o_zero, o_carry, o_odd, o_exec, o_halted, o_fault, o_instr_count
  );

  modport slave (
    input  i_control_word, i_alu_zero, i_alu_carry, i_alu_odd, i_run, i_step_req,
    output o_step, o_zero, o_carry, o_odd, o_exec, o_halted, o_fault, o_instr_count
  );
endinterface

// File: rtl/step_edge_detect.sv
// Registers a level input and emits a one-cycle pulse on its registered 0->1 edge.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic q, q_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= 1'b0;
      q_prev <= 1'b0;
    end else begin
      q      <= d;
      q_prev <= q;
    end
  end

  assign pulse = q & ~q_prev;
endmodule

// File: rtl/step_sequencer.sv
// SAP-1 step sequencer: step counter, latched ALU flags, halt/fault state and
// the single execute enable. Optional instruction counter: SEQ_INSTR_COUNT_EN.
module step_sequencer
  import sap1_ctrl_pkg::*;
#(
  parameter int INSTRUCTION_STEPS  = 8,
  parameter int CONTROL_WORD_WIDTH = CW_WIDTH
) (
  input logic             i_clk,
  input logic             i_reset,
  step_sequencer_if.slave sif
);
  localparam int STEP_WIDTH = $clog2(INSTRUCTION_STEPS);
  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  seq_state_t            state;
  logic [STEP_WIDTH-1:0] step;
  logic [2:0]            flags;
  logic                  step_pulse, exec;
  logic                  adv, hlt, el;
  logic                  unused_cw;

  assign adv       = sif.i_control_word[C_ADV];
  assign hlt       = sif.i_control_word[C_HLT];
  assign el        = sif.i_control_word[C_EL];
  assign unused_cw = ^sif.i_control_word;

  step_edge_detect u_step_edge (
    .clk   (i_clk),
    .rst   (i_reset),
    .d     (sif.i_step_req),
    .pulse (step_pulse)
  );

  assign exec = (state == ST_RUN) && (sif.i_run || step_pulse);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_RUN;
      step  <= '0;
      flags <= '0;
    end else if (exec) begin
      // Halt beats advance, so the step of the halting word stays visible
      if (hlt)                    state <= ST_HALTED;
      else if (adv)               step  <= '0;
      else if (step == LAST_STEP) state <= ST_FAULT;
      else                        step  <= step + 1'b1;
      if (el) flags <= {sif.i_alu_zero, sif.i_alu_carry, sif.i_alu_odd};
    end
  end

`ifdef SEQ_INSTR_COUNT_EN
  logic [CNT_W-1:0] instr_count;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      instr_count <= '0;
    else if (exec && adv && !hlt && (instr_count != {CNT_W{1'b1}}))
      instr_count <= instr_count + 1'b1;
  end

  assign sif.o_instr_count = instr_count;
`else
  assign sif.o_instr_count = '0;
`endif

  assign sif.o_step                          = step;
  assign {sif.o_zero, sif.o_carry, sif.o_odd} = flags;
  assign sif.o_exec                          = exec;
  assign sif.o_halted                        = (state == ST_HALTED);
  assign sif.o_fault                         = (state == ST_FAULT);
endmodule

// File: tb/tb_step_sequencer.sv
// Randomized + directed bench for step_sequencer against a behavioural model.
module tb_step_sequencer;
  import sap1_ctrl_pkg::*;

  localparam int N  = 8;
  localparam int SW = $clog2(N);
  localparam int CW = CW_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  step_sequencer_if #(.CONTROL_WORD_WIDTH(CW), .STEP_WIDTH(SW)) sif ();

  step_sequencer #(.INSTRUCTION_STEPS(N), .CONTROL_WORD_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .sif     (sif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  bit       m_valid = 0;
  int       m_step  = 0;
  bit [2:0] m_flags = 0;
  bit       m_halted = 0, m_fault = 0;
  int       m_count = 0;
  bit       m_req_q = 0, m_req_p = 0;

  function automatic bit model_exec(input bit run);
    return !m_halted && !m_fault && (run || (m_req_q && !m_req_p));
  endfunction

  task automatic tick(input bit r, input logic [CW-1:0] cw, input bit [2:0] fl,
                      input bit run, input bit req);
    bit ex;
    @(negedge clk);
    rst                = r;
    sif.i_control_word = cw;
    {sif.i_alu_zero, sif.i_alu_carry, sif.i_alu_odd} = fl;
    sif.i_run          = run;
    sif.i_step_req     = req;
    #1;
    ex = model_exec(run);
    if (m_valid) chk("exec", sif.o_exec, ex);
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1; m_step = 0; m_flags = 0; m_halted = 0; m_fault = 0;
      m_count = 0; m_req_q = 0; m_req_p = 0;
    end else begin
      if (ex) begin
        if (cw[C_HLT]) m_halted = 1;
        else if (cw[C_ADV]) begin
          m_step = 0;
          if (m_count < 65535) m_count++;
        end
        else if (m_step == N - 1) m_fault = 1;
        else m_step++;
        if (cw[C_EL]) m_flags = fl;
      end
      m_req_p = m_req_q;
      m_req_q = req;
    end
    chk("step",   sif.o_step, m_step);
    chk("flags",  {sif.o_zero, sif.o_carry, sif.o_odd}, m_flags);
    chk("halted", sif.o_halted, m_halted);
    chk("fault",  sif.o_fault, m_fault);
`ifdef SEQ_INSTR_COUNT_EN
    chk("count",  sif.o_instr_count, m_count);
`else
    chk("count",  sif.o_instr_count, 0);
`endif
  endtask

  function automatic logic [CW-1:0] bitw(input int idx);
    logic [CW-1:0] w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  logic [CW-1:0] w_adv, w_hlt, w_el;

  initial begin
    w_adv = bitw(C_ADV);
    w_hlt = bitw(C_HLT);
    w_el  = bitw(C_EL);
    sif.i_control_word = '0;
    {sif.i_alu_zero, sif.i_alu_carry, sif.i_alu_odd} = 3'b000;
    sif.i_run = 1'b1;
    sif.i_step_req = 1'b0;

    // Reset state
    tick(1, '0, 3'b000, 1, 0);
    tick(1, '0, 3'b000, 1, 0);
    chk("rst_step", sif.o_step, 0);
    chk("rst_halted", sif.o_halted, 0);

    // Free-run 3-step instructions: 0,1,2,0,1,2
    for (int i = 0; i < 6; i++)
      tick(0, (m_step == 2) ? w_adv : '0, 3'b000, 1, 0);
    chk("loop_step", sif.o_step, 0);

    // Flag latch, then non-latching word leaves flags alone
    tick(0, w_el, 3'b101, 1, 0);
    chk("el_flags", {sif.o_zero, sif.o_carry, sif.o_odd}, 3'b101);
    tick(0, w_adv, 3'b010, 1, 0);
    chk("keep_flags", {sif.o_zero, sif.o_carry, sif.o_odd}, 3'b101);

    // Halt with advance at step 2
    tick(1, '0, 3'b000, 1, 0);
    tick(0, '0, 3'b000, 1, 0);
    tick(0, '0, 3'b000, 1, 0);
    tick(0, w_hlt | w_adv, 3'b000, 1, 0);
    for (int i = 0; i < 4; i++) tick(0, w_adv, 3'b111, 1, 1);
    chk("hlt_step", sif.o_step, 2);
    chk("hlt_flag", sif.o_halted, 1);
    tick(1, '0, 3'b000, 1, 0);
    chk("hlt_rst_step", sif.o_step, 0);
    chk("hlt_rst_flag", sif.o_halted, 0);

    // Step overflow without advance
    for (int i = 0; i < N; i++) tick(0, '0, 3'b000, 1, 0);
    chk("fault_flag", sif.o_fault, 1);
    chk("fault_step", sif.o_step, N - 1);
    tick(0, w_adv, 3'b000, 1, 0);
    chk("fault_sticky", sif.o_fault, 1);

    // Single-step: three held presses
    tick(1, '0, 3'b000, 0, 0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) tick(0, '0, 3'b000, 0, 1);
      for (int i = 0; i < 5; i++) tick(0, '0, 3'b000, 0, 0);
    end
    chk("sstep_step", sif.o_step, 3);

    // Four instructions then halt
    tick(1, '0, 3'b000, 1, 0);
    for (int i = 0; i < 12; i++)
      tick(0, (m_step == 2) ? w_adv : '0, 3'b000, 1, 0);
    tick(0, w_hlt, 3'b000, 1, 0);
`ifdef SEQ_INSTR_COUNT_EN
    chk("icount", sif.o_instr_count, 4);
`else
    chk("icount", sif.o_instr_count, 0);
`endif

    // Randomized traffic with occasional resets and mode switches
    for (int i = 0; i < 400; i++) begin
      logic [CW-1:0] cw;
      cw = CW'($urandom);
      cw[C_ADV] = ($urandom_range(0, 2) == 0);
      cw[C_HLT] = ($urandom_range(0, 39) == 0);
      cw[C_EL]  = $urandom_range(0, 1);
      tick($urandom_range(0, 24) == 0, cw, 3'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
